// File: rtl/debounce_filter.sv
// debounce_filter: per-bit debounce filter, output switches after DEBOUNCE_CYCLES consecutive differing enabled samples
module debounce_filter #(
  parameter int WIDTH = 1,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             ena,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CHECK = 1'b1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [0:0] st;
    logic [CW-1:0] cnt;
    logic o, r, f, diff, done;
    assign diff = in[i] ^ o;
    // single-cycle filter switches straight from IDLE; otherwise the last count step switches
    assign done = diff && (DEBOUNCE_CYCLES == 1 || (st == CHECK && cnt == CW'(DEBOUNCE_CYCLES - 1)));
    always_ff @(posedge clk) begin
      if (!nrst) begin
        o <= INIT[i];
        st <= IDLE;
        cnt <= '0;
        r <= 1'b0;
        f <= 1'b0;
      end else begin
        r <= ena && done && in[i];
        f <= ena && done && !in[i];
        if (ena) begin
          if (!diff || done) begin
            st <= IDLE;
            cnt <= '0;
            o <= in[i];
          end else begin
            st <= CHECK;
            cnt <= cnt + 1'b1;
          end
        end
      end
    end
    assign out[i] = o;
    assign rise[i] = r;
    assign fall[i] = f;
  end
endmodule

// File: tb/tb_debounce_filter.sv
// tb_debounce_filter: scoreboard bench against a sample-history reference model
module tb_debounce_filter;
  localparam int D = 4;
  localparam logic [1:0] INIT = 2'b00;
  logic clk, nrst, ena;
  logic [1:0] in, out, rise, fall;
  logic [5:0] exp_q[$];
  logic [1:0] hist[$];
  logic [1:0] mo;
  int ls[2];
  int errors = 0, checks = 0;

  debounce_filter #(.WIDTH(2), .DEBOUNCE_CYCLES(D), .INIT(INIT)) dut (
    .clk(clk), .nrst(nrst), .ena(ena), .in(in), .out(out), .rise(rise), .fall(fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [1:0] got, input logic [1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got=%b want=%b", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [5:0] e;
      e = exp_q.pop_front();
      chk("out", out, e[5:4]);
      chk("rise", rise, e[3:2]);
      chk("fall", fall, e[1:0]);
    end
  end

  // out flips once the last D enabled samples since the previous flip all differ from it
  task automatic step(input bit r, input bit e, input logic [1:0] v);
    logic [1:0] er, ef;
    nrst = r;
    ena = e;
    in = v;
    er = 2'b00;
    ef = 2'b00;
    if (!r) begin
      mo = INIT;
      hist.delete();
      ls[0] = 0;
      ls[1] = 0;
    end else if (e) begin
      hist.push_back(v);
      for (int i = 0; i < 2; i++) begin
        int n;
        bit all;
        n = hist.size();
        if (n - ls[i] >= D) begin
          all = 1'b1;
          for (int j = n - D; j < n; j++) if (hist[j][i] == mo[i]) all = 1'b0;
          if (all) begin
            mo[i] = v[i];
            er[i] = v[i];
            ef[i] = !v[i];
            ls[i] = n;
          end
        end
      end
    end
    @(posedge clk);
    exp_q.push_back({mo, er, ef});
    #1;
  endtask

  task automatic rep(input int k, input bit r, input bit e, input logic [1:0] v);
    for (int i = 0; i < k; i++) step(r, e, v);
  endtask

  initial begin
    logic [1:0] v;
    mo = INIT;
    ls[0] = 0;
    ls[1] = 0;
    rep(2, 0, 1, 2'b11);
    rep(6, 1, 1, 2'b01);
    rep(5, 1, 1, 2'b00);
    rep(3, 1, 1, 2'b01);
    rep(2, 1, 1, 2'b00);
    rep(5, 1, 1, 2'b01);
    rep(1, 0, 1, 2'b00);
    rep(2, 1, 1, 2'b10);
    rep(5, 1, 0, 2'b10);
    rep(3, 1, 1, 2'b10);
    rep(1, 0, 1, 2'b00);
    rep(3, 1, 1, 2'b01);
    rep(1, 0, 1, 2'b01);
    rep(6, 1, 1, 2'b01);
    rep(6, 1, 1, 2'b11);
    rep(6, 1, 1, 2'b00);
    v = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 2; b++) if ($urandom_range(3) == 0) v[b] = ~v[b];
      step($urandom_range(49) != 0, $urandom_range(9) != 0, v);
    end
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got=%0d pending want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
